// File: rtl/pipe_skid_reg.sv
// Two-entry skid register between pipeline stages: up_ready is registered, so dn_ready never reaches it combinationally.
// Optional feature macro PIPE_SKID_PERF_CNT_EN adds saturating stall/bubble counters.
`timescale 1ns/1ps

module pipe_skid_reg #(
    parameter int DATA_W     = 32,
    parameter int FLUSH_ZERO = 1,
    parameter int CNT_W      = 32
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data
`ifdef PIPE_SKID_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    if (DATA_W < 1 || DATA_W > 512 || CNT_W < 1 || FLUSH_ZERO < 0 || FLUSH_ZERO > 1) begin : g_bad_param
        $error("pipe_skid_reg: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              up_acc;
    logic              dn_acc;

    assign up_acc  = up_valid & up_ready;
    assign dn_acc  = dn_valid & dn_ready;
    assign dn_data = main_q;

    // NOTE: state is updated with non-blocking assignments only, so every branch below reads the
    // pre-edge values of state/main_q/skid_q regardless of statement order.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            // NOTE: both payload registers are reset because dn_data and the skid entry must read zero in reset.
            state    <= ST_EMPTY;
            dn_valid <= 1'b0;
            up_ready <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            state    <= ST_EMPTY;
            dn_valid <= 1'b0;
            up_ready <= 1'b1;
            if (FLUSH_ZERO != 0) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    // up_ready is still 0 on the first edge after reset, so no accept can happen then.
                    up_ready <= 1'b1;
                    if (up_acc) begin
                        state    <= ST_ONE;
                        main_q   <= up_data;
                        dn_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (up_acc && dn_acc) begin
                        main_q <= up_data;
                    end else if (up_acc) begin
                        state    <= ST_FULL;
                        skid_q   <= up_data;
                        up_ready <= 1'b0;
                    end else if (dn_acc) begin
                        state    <= ST_EMPTY;
                        dn_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (dn_acc) begin
                        state    <= ST_ONE;
                        main_q   <= skid_q;
                        up_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_EMPTY;
                    dn_valid <= 1'b0;
                    up_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_PERF_CNT_EN
    // Counters see the registered dn_valid, so they lag the handshake by one cycle and ignore flush.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (dn_valid && !dn_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (!dn_valid && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    a_valid_tracks_state : assert property (
        @(posedge cpu_clk_50M) disable iff (!cpu_rst_n)
        dn_valid == (state != ST_EMPTY));

    a_full_blocks_upstream : assert property (
        @(posedge cpu_clk_50M) disable iff (!cpu_rst_n)
        (state == ST_FULL) |-> !up_ready);

    a_stall_holds_payload : assert property (
        @(posedge cpu_clk_50M) disable iff (!cpu_rst_n)
        (dn_valid && !dn_ready && !flush) |=> (dn_valid && $stable(dn_data)));
`endif

endmodule
